// File: rtl/c499_access_ctrl.sv
// rtl/c499_access_ctrl.sv - two-requester arbiter and sequencer for a shared c499 SEC core
module c499_access_ctrl #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [40:0]      req_data0,
    input  logic [40:0]      req_data1,
    output logic [40:0]      dut_in,
    input  logic [31:0]      dut_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // The settle counter is loaded with SETTLE-1 so that the capture lands
    // exactly SETTLE edges after the accept edge.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic [7:0] settle_cnt;

    // Round-robin pick: a lone requester wins outright, a tie goes to the one not served last
    always_comb begin
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req_valid[1];
        end
    end

    assign accept = (state == S_IDLE) && (req_valid != 2'b00);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == 8'd0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state: one-hot ready in IDLE only, busy elsewhere
    always_comb begin
        req_ready = 2'b00;
        busy      = (state != S_IDLE);
        if (accept) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    // Datapath: latch the granted vector, count down the settle time, capture and retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in     <= '0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            txn_count  <= '0;
            settle_cnt <= 8'd0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dut_in     <= grant ? req_data1 : req_data0;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt != 8'd0) begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end else begin
                        rsp_data  <= dut_out;
                        rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_c499_access_ctrl.sv
// tb/tb_c499_access_ctrl.sv - randomized self-checking bench for c499_access_ctrl
module tb_c499_access_ctrl;

    localparam int SETTLE = 2;
    localparam int CNT_W  = 4;
    localparam int NRAND  = 1000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [40:0]      req_data0;
    logic [40:0]      req_data1;
    logic [40:0]      dut_in;
    logic [31:0]      dut_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [31:0]      rsp_data;
    logic             busy;
    logic [CNT_W-1:0] txn_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    c499_access_ctrl #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .txn_count (txn_count)
    );

    // Functional SEC core: in[31:0] data, in[39:32] check bits, in[40] correction enable.
    // Data bit i has parity column 8'hE0|i; a syndrome equal to a column flips that bit.
    function automatic logic [31:0] c499_fn(input logic [40:0] v);
        logic [7:0]  syn;
        logic [31:0] d;
        d   = v[31:0];
        syn = v[39:32];
        for (int i = 0; i < 32; i++) begin
            if (d[i]) syn = syn ^ (8'hE0 | 8'(i));
        end
        if (v[40]) begin
            for (int i = 0; i < 32; i++) begin
                if (syn == (8'hE0 | 8'(i))) d[i] = ~d[i];
            end
        end
        return d;
    endfunction

    assign dut_out = c499_fn(dut_in);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: transaction-level view driven by absolute edge numbers
    int               cyc = 0;
    bit               m_idle;
    bit               m_last;
    logic [40:0]      m_in;
    bit               m_rv;
    logic [31:0]      m_data;
    bit               m_id;
    int               m_due;
    logic [CNT_W-1:0] m_count;
    bit               m_g;
    logic [1:0]       m_er;

    logic [40:0] exp_q0[$];
    logic [40:0] exp_q1[$];
    logic [40:0] popped;
    bit          acc_flag[2];
    int          acc_total = 0;
    int          rsp_total = 0;
    int          acc_cyc[$];
    bit          acc_id[$];

    // Compare process: checks every output against the model, then advances the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_idle  = 1'b1;
                m_last  = 1'b1;
                m_in    = '0;
                m_rv    = 1'b0;
                m_data  = '0;
                m_id    = 1'b0;
                m_due   = 0;
                m_count = '0;
                exp_q0.delete();
                exp_q1.delete();
                acc_cyc.delete();
                acc_id.delete();
                acc_total = 0;
                rsp_total = 0;
            end else begin
                m_g  = (req_valid == 2'b11) ? ~m_last : req_valid[1];
                m_er = (m_idle && req_valid != 2'b00) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
                chk("req_ready", 64'(req_ready), 64'(m_er));
                chk("busy", 64'(busy), 64'(!m_idle));
                chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
                chk("rsp_id", 64'(rsp_id), 64'(m_id));
                chk("rsp_data", 64'(rsp_data), 64'(m_data));
                chk("dut_in", 64'(dut_in), 64'(m_in));
                chk("txn_count", 64'(txn_count), 64'(m_count));

                if (req_valid[0] && req_ready[0]) begin
                    exp_q0.push_back(req_data0);
                    acc_flag[0] = 1'b1;
                    acc_total++;
                    acc_cyc.push_back(cyc);
                    acc_id.push_back(1'b0);
                end
                if (req_valid[1] && req_ready[1]) begin
                    exp_q1.push_back(req_data1);
                    acc_flag[1] = 1'b1;
                    acc_total++;
                    acc_cyc.push_back(cyc);
                    acc_id.push_back(1'b1);
                end
                if (rsp_valid && rsp_ready) begin
                    rsp_total++;
                    checks++;
                    if ((rsp_id ? exp_q1.size() : exp_q0.size()) == 0) begin
                        errors++;
                        $display("FAIL rsp_dup actual=response_for_id_%0d required=no_response t=%0t", rsp_id, $time);
                    end else begin
                        popped = rsp_id ? exp_q1.pop_front() : exp_q0.pop_front();
                        chk("rsp_golden", 64'(rsp_data), 64'(c499_fn(popped)));
                    end
                end

                if (m_idle) begin
                    if (req_valid != 2'b00) begin
                        m_idle = 1'b0;
                        m_in   = m_g ? req_data1 : req_data0;
                        m_id   = m_g;
                        m_last = m_g;
                        m_due  = cyc + SETTLE;
                    end
                end else if (!m_rv) begin
                    if (cyc == m_due) begin
                        m_rv   = 1'b1;
                        m_data = c499_fn(m_in);
                    end
                end else if (rsp_ready) begin
                    m_rv    = 1'b0;
                    m_count = m_count + 1'b1;
                    m_idle  = 1'b1;
                end
            end
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] rnd;
    logic [40:0] vec[2];
    bit          pend[2];
    int          issued;
    logic [40:0] pin_v;

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();

        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_dut_in", 64'(dut_in), 64'd0);
        chk("reset_txn_count", 64'(txn_count), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);

        pin_v = 41'h1_E5_0000_0000;
        chk("model_pin_syn", 64'(c499_fn(pin_v)), 64'h0000_0020);
        pin_v = 41'h1_00_0000_0001;
        chk("model_pin_fix", 64'(c499_fn(pin_v)), 64'h0000_0000);
        pin_v = 41'h155_5555_5555;
        chk("model_pin_clean", 64'(c499_fn(pin_v)), 64'h5555_5555);

        rst_n = 1'b1;
        tick();

        // Single request from requester 0, then a 10-cycle response stall
        req_valid = 2'b01;
        req_data0 = 41'h155_5555_5555;
        tick();
        req_valid = 2'b00;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_rv_n1", 64'(rsp_valid), 64'd0);
        tick();
        chk("t1_rv_n1b", 64'(rsp_valid), 64'd0);
        tick();
        chk("t1_rv_n2", 64'(rsp_valid), 64'd1);
        chk("t1_id", 64'(rsp_id), 64'd0);
        chk("t1_data", 64'(rsp_data), 64'h5555_5555);

        req_valid = 2'b11;
        rnd = {$urandom, $urandom};
        req_data1 = rnd[40:0];
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t3_rv", 64'(rsp_valid), 64'd1);
            chk("t3_data", 64'(rsp_data), 64'h5555_5555);
            chk("t3_id", 64'(rsp_id), 64'd0);
            chk("t3_ready", 64'(req_ready), 64'd0);
            chk("t3_busy", 64'(busy), 64'd1);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t3_idle", 64'(busy), 64'd0);
        chk("t3_rv_low", 64'(rsp_valid), 64'd0);
        chk("t3_count", 64'(txn_count), 64'd1);

        // Reset in the middle of SETTLE drops the transaction
        req_valid = 2'b01;
        rnd = {$urandom, $urandom};
        req_data0 = rnd[40:0];
        tick();
        req_valid = 2'b00;
        chk("t4_in_settle", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_rv", 64'(rsp_valid), 64'd0);
        chk("t4_dut_in", 64'(dut_in), 64'd0);
        chk("t4_count", 64'(txn_count), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        tick();

        // Both requesters held valid: alternating grants starting at 0
        acc_flag[0] = 1'b0;
        acc_flag[1] = 1'b0;
        rnd = {$urandom, $urandom};
        req_data0 = rnd[40:0];
        rnd = {$urandom, $urandom};
        req_data1 = rnd[40:0];
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        rst_n     = 1'b1;
        for (int k = 0; k < 100 && acc_cyc.size() < 6; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (acc_flag[i]) begin
                    acc_flag[i] = 1'b0;
                    rnd = {$urandom, $urandom};
                    if (i == 0) req_data0 = rnd[40:0];
                    else        req_data1 = rnd[40:0];
                end
            end
        end
        req_valid = 2'b00;
        chk("t2_accepts", 64'(acc_cyc.size()), 64'd6);
        for (int k = 0; k < 6 && k < acc_cyc.size(); k++) begin
            chk("t2_id_seq", 64'(acc_id[k]), 64'(k % 2));
            if (k > 0) chk("t2_interval", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(SETTLE + 2));
        end
        for (int k = 0; k < 50 && busy; k++) tick();

        // Run through the 4-bit counter wrap: 17 completions leave 1
        for (int k = 0; k < 400 && !(rsp_total >= 17 && !busy); k++) begin
            if (acc_flag[0]) begin
                acc_flag[0] = 1'b0;
                rnd = {$urandom, $urandom};
                req_data0 = rnd[40:0];
            end
            req_valid = (acc_total < 17) ? 2'b01 : 2'b00;
            tick();
        end
        req_valid = 2'b00;
        chk("t5_total", 64'(rsp_total), 64'd17);
        chk("t5_wrap", 64'(txn_count), 64'd1);

        // Random vectors, random requesters, random stalls
        acc_flag[0] = 1'b0;
        acc_flag[1] = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        issued  = 0;
        for (int k = 0; k < 40000 && !(issued == NRAND && !pend[0] && !pend[1] && !busy); k++) begin
            for (int i = 0; i < 2; i++) begin
                if (acc_flag[i]) begin
                    acc_flag[i] = 1'b0;
                    pend[i] = 1'b0;
                end
                if (!pend[i] && issued < NRAND && $urandom_range(0, 2) != 0) begin
                    rnd = {$urandom, $urandom};
                    vec[i]  = rnd[40:0];
                    pend[i] = 1'b1;
                    issued++;
                end
                req_valid[i] = pend[i] && ($urandom_range(0, 7) != 0);
            end
            req_data0 = vec[0];
            req_data1 = vec[1];
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("t6_issued", 64'(issued), 64'(NRAND));
        chk("t6_total", 64'(rsp_total), 64'(17 + NRAND));
        chk("t6_lost", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        chk("t6_count", 64'(txn_count), 64'((17 + NRAND) % 16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
